// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Multi-channel conditioner for asynchronous board inputs.
//            Each channel is synchronised, optionally inverted, debounced
//            and edge-detected. Selected edges latch into sticky capture
//            bits with per-bit write-1-to-clear and a maskable irq.
// Revision : 1.0  initial release
// ============================================================================
module input_conditioner #(
  parameter int           N               = 16,
  parameter int           SYNC_STAGES     = 2,
  parameter int           DEBOUNCE_CYCLES = 500000,
  parameter logic [N-1:0] INVERT          = {N{1'b0}},
  parameter int           CAPTURE_EDGE    = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] raw_in,
  input  logic [N-1:0] clr_capture,
  input  logic [N-1:0] irq_mask,
  output logic [N-1:0] level_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] capture,
  output logic         irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Every channel owns its own synchroniser, counter and capture bit.
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   cap_q, cap_d;
    logic                   s;
    logic                   cap_set;

    // Next-state: shift the synchroniser, run the debounce counter, and
    // derive edge pulses and the sticky capture bit from the level toggle.
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in[i]};
      s       = sync_q[SYNC_STAGES-1] ^ INVERT[i];
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s != level_q) begin
        if (cnt_q == CNT_LAST) begin
          // Stable long enough: accept the new level; counter restarts.
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (CAPTURE_EDGE == 0) begin
        cap_set = rise_d;
      end else if (CAPTURE_EDGE == 1) begin
        cap_set = fall_d;
      end else begin
        cap_set = rise_d | fall_d;
      end
      // A new event beats a coincident clear so no edge is ever lost.
      cap_d = cap_set | (cap_q & ~clr_capture[i]);
    end

    // State registers; synchroniser resets to the idle raw level so an
    // active-low input does not produce a spurious edge after reset.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        sync_q  <= {SYNC_STAGES{INVERT[i]}};
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cap_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        cap_q   <= cap_d;
      end
    end

    assign level_out[i] = level_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;
    assign capture[i]   = cap_q;
  end : g_ch

  assign irq = |(capture & irq_mask);

endmodule
`default_nettype wire
